// File: rtl/cam_cfg_sequencer_pkg.sv
// Shared constants for the camera configuration sequencer and the camera ROM image.
package cam_cfg_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_WAIT_RDY,
    S_ISSUE,
    S_WAIT_DONE,
    S_DELAY,
    S_DONE
  } cfg_state_t;

  localparam logic [15:0] CFG_END_MARKER   = 16'hFFFF;
  localparam logic [15:0] CFG_DELAY_MARKER = 16'hF0F0;

endpackage

// File: rtl/cam_cfg_sequencer_delay_timer.sv
// Loadable down-counter that stops at zero; zero flag is combinational from the count.
module cfg_delay_timer #(
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/cam_cfg_sequencer.sv
// Walks the camera register ROM, issuing SCCB writes with NACK retry,
// honouring delay markers and stopping at the end marker or the last ROM address.
module cam_cfg_sequencer
  import cam_cfg_sequencer_pkg::*;
#(
  parameter int ROM_AW       = 8,
  parameter int DELAY_CYCLES = 500_000,
  parameter int MAX_RETRY    = 3
) (
  input  logic              i_sysclk,
  input  logic              i_rst,
  input  logic              i_cfg_start,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [15:0]       i_rom_data,
  input  logic              i_sccb_ready,
  output logic              o_sccb_start,
  output logic [7:0]        o_sccb_addr,
  output logic [7:0]        o_sccb_data,
  input  logic              i_sccb_done,
  input  logic              i_sccb_nack,
  output logic              o_cfg_busy,
  output logic              o_cfg_done,
  output logic              o_cfg_error
);

  localparam int CW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  cfg_state_t    state;
  logic [RW-1:0] retry;
  logic          delay_load;
  logic          delay_zero;

  assign delay_load = (state == S_DECODE) && (i_rom_data == CFG_DELAY_MARKER);

  cfg_delay_timer #(
    .W (CW)
  ) u_delay (
    .clk      (i_sysclk),
    .rst      (i_rst),
    .load     (delay_load),
    .load_val (CW'(DELAY_CYCLES - 1)),
    .en       (state == S_DELAY),
    .zero     (delay_zero)
  );

  always_ff @(posedge i_sysclk or posedge i_rst) begin
    if (i_rst) begin
      state        <= S_IDLE;
      o_rom_addr   <= '0;
      o_sccb_addr  <= '0;
      o_sccb_data  <= '0;
      retry        <= '0;
      o_sccb_start <= 1'b0;
      o_cfg_busy   <= 1'b0;
      o_cfg_done   <= 1'b0;
      o_cfg_error  <= 1'b0;
    end else begin
      o_sccb_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_cfg_start) begin
            o_rom_addr  <= '0;
            o_cfg_done  <= 1'b0;
            o_cfg_error <= 1'b0;
            retry       <= '0;
            o_cfg_busy  <= 1'b1;
            state       <= S_FETCH;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          if (i_rom_data == CFG_END_MARKER) begin
            state <= S_DONE;
          end else if (i_rom_data == CFG_DELAY_MARKER) begin
            state <= S_DELAY;
          end else begin
            o_sccb_addr <= i_rom_data[15:8];
            o_sccb_data <= i_rom_data[7:0];
            state       <= S_WAIT_RDY;
          end
        end
        S_WAIT_RDY: begin
          if (i_sccb_ready) begin
            o_sccb_start <= 1'b1;
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_WAIT_DONE;
        S_WAIT_DONE: begin
          if (i_sccb_done) begin
            if (!i_sccb_nack) begin
              retry <= '0;
              // Last ROM address acts as an implicit end marker instead of wrapping.
              if (o_rom_addr == '1) begin
                state <= S_DONE;
              end else begin
                o_rom_addr <= o_rom_addr + 1'b1;
                state      <= S_FETCH;
              end
            end else if (retry < RW'(MAX_RETRY)) begin
              retry <= retry + 1'b1;
              state <= S_WAIT_RDY;
            end else begin
              o_cfg_error <= 1'b1;
              state       <= S_DONE;
            end
          end
        end
        S_DELAY: begin
          if (delay_zero) begin
            if (o_rom_addr == '1) begin
              state <= S_DONE;
            end else begin
              o_rom_addr <= o_rom_addr + 1'b1;
              state      <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          o_cfg_done <= 1'b1;
          o_cfg_busy <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// Directed vector bench for cam_cfg_sequencer with a ROM model and a fixed-latency SCCB responder.
module tb_cam_cfg_sequencer;

  localparam int AW  = 2;
  localparam int LAT = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_start = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data = '0;
  logic          sccb_ready = 1'b1;
  logic          sccb_start;
  logic [7:0]    sccb_addr;
  logic [7:0]    sccb_data;
  logic          sccb_done = 1'b0;
  logic          sccb_nack = 1'b0;
  logic          cfg_busy;
  logic          cfg_done;
  logic          cfg_error;

  cam_cfg_sequencer #(
    .ROM_AW       (AW),
    .DELAY_CYCLES (16),
    .MAX_RETRY    (3)
  ) dut (
    .i_sysclk     (clk),
    .i_rst        (rst),
    .i_cfg_start  (cfg_start),
    .o_rom_addr   (rom_addr),
    .i_rom_data   (rom_data),
    .i_sccb_ready (sccb_ready),
    .o_sccb_start (sccb_start),
    .o_sccb_addr  (sccb_addr),
    .o_sccb_data  (sccb_data),
    .i_sccb_done  (sccb_done),
    .i_sccb_nack  (sccb_nack),
    .o_cfg_busy   (cfg_busy),
    .o_cfg_done   (cfg_done),
    .o_cfg_error  (cfg_error)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [4];
  always @(posedge clk) rom_data <= rom[rom_addr];

  // SCCB responder: mode 0 acks all, 1 nacks the first write of a run, 2 nacks all.
  int          mode = 0;
  int          start_base = 0;
  int          start_count = 0;
  int          busy_cycles = 0;
  int          sccb_cnt = 0;
  logic [15:0] log_q [$];

  always @(negedge clk) begin
    if (cfg_busy) busy_cycles++;
    sccb_done = 1'b0;
    sccb_nack = 1'b0;
    if (rst) begin
      sccb_cnt   = 0;
      sccb_ready = 1'b1;
    end else if (sccb_start) begin
      log_q.push_back({sccb_addr, sccb_data});
      start_count++;
      sccb_ready = 1'b0;
      sccb_cnt   = LAT;
    end else if (sccb_cnt != 0) begin
      sccb_cnt--;
      if (sccb_cnt == 0) begin
        sccb_done  = 1'b1;
        sccb_nack  = (mode == 2) || (mode == 1 && start_count == start_base + 1);
        sccb_ready = 1'b1;
      end
    end
  end

  int pass_cnt = 0;
  int total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [15:0] r0, r1, r2, r3;
    int          mode;
    bit          mid_start;
    int          starts;
    int          busy;
    logic [1:0]  addr;
    logic [15:0] first, last;
    logic        err;
  } vec_t;

  vec_t vecs [5];

  task automatic pulse_start();
    @(negedge clk) cfg_start = 1'b1;
    @(negedge clk) cfg_start = 1'b0;
  endtask

  task automatic wait_idle(input bit mid);
    for (int k = 0; k < 2000 && cfg_busy; k++) begin
      @(negedge clk);
      cfg_start = (mid && k == 20);
    end
    cfg_start = 1'b0;
    check("idle_timeout", {31'd0, cfg_busy}, 32'd0);
  endtask

  initial begin
    // write entries, delay marker, nack-once, nack-always, no end marker with stray start
    vecs[0] = '{16'h1280, 16'h1100, 16'hFFFF, 16'h0000, 0, 1'b0, 2, 31, 2'd2, 16'h1280, 16'h1100, 1'b0};
    vecs[1] = '{16'hF0F0, 16'hFFFF, 16'h1280, 16'h1100, 0, 1'b0, 0, 21, 2'd1, 16'h0000, 16'h0000, 1'b0};
    vecs[2] = '{16'h1280, 16'h1100, 16'hFFFF, 16'h0000, 1, 1'b0, 3, 43, 2'd2, 16'h1280, 16'h1100, 1'b0};
    vecs[3] = '{16'h1280, 16'h1100, 16'hFFFF, 16'h0000, 2, 1'b0, 4, 51, 2'd0, 16'h1280, 16'h1280, 1'b1};
    vecs[4] = '{16'h1280, 16'h1100, 16'h1301, 16'h1402, 0, 1'b1, 4, 57, 2'd3, 16'h1280, 16'h1402, 1'b0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {26'd0, rom_addr, sccb_start, cfg_busy, cfg_done, cfg_error},
          32'd0);
    check("reset_sccb_regs", {16'd0, sccb_addr, sccb_data}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      int b0;
      int s0;
      logic [AW-1:0] end_addr;
      rom[0] = vecs[i].r0; rom[1] = vecs[i].r1; rom[2] = vecs[i].r2; rom[3] = vecs[i].r3;
      mode       = vecs[i].mode;
      s0         = start_count;
      start_base = s0;
      b0         = busy_cycles;
      pulse_start();
      wait_idle(vecs[i].mid_start);
      end_addr = rom_addr;
      repeat (6) @(negedge clk);
      check($sformatf("v%0d_starts", i), start_count - s0, vecs[i].starts);
      check($sformatf("v%0d_busy_cycles", i), busy_cycles - b0, vecs[i].busy);
      check($sformatf("v%0d_done", i), {31'd0, cfg_done}, 32'd1);
      check($sformatf("v%0d_error", i), {31'd0, cfg_error}, {31'd0, vecs[i].err});
      check($sformatf("v%0d_end_addr", i), {30'd0, end_addr}, {30'd0, vecs[i].addr});
      check($sformatf("v%0d_addr_held", i), {30'd0, rom_addr}, {30'd0, vecs[i].addr});
      check($sformatf("v%0d_still_idle", i), {31'd0, cfg_busy}, 32'd0);
      if (start_count - s0 > 0) begin
        check($sformatf("v%0d_first_write", i), {16'd0, log_q[s0]}, {16'd0, vecs[i].first});
        check($sformatf("v%0d_last_write", i), {16'd0, log_q[start_count - 1]},
              {16'd0, vecs[i].last});
      end
      if (vecs[i].mode == 1 && start_count - s0 > 1)
        check("retry_same_entry", {16'd0, log_q[s0 + 1]}, {16'd0, log_q[s0]});
    end

    // Asynchronous reset in the middle of a write, then a clean restart from address 0.
    begin
      int s0;
      rom[0] = 16'h1280; rom[1] = 16'h1100; rom[2] = 16'hFFFF; rom[3] = 16'h0000;
      mode = 0;
      s0 = start_count;
      start_base = s0;
      pulse_start();
      for (int k = 0; k < 200 && start_count == s0; k++) @(negedge clk);
      repeat (3) @(negedge clk);
      check("pre_reset_busy", {31'd0, cfg_busy}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("async_reset_outputs",
            {10'd0, rom_addr, sccb_addr, sccb_data, sccb_start, cfg_busy, cfg_done, cfg_error},
            32'd0);
      @(negedge clk) rst = 1'b0;
      repeat (12) @(negedge clk);
      check("post_reset_no_action", {29'd0, cfg_busy, rom_addr}, 32'd0);
      s0 = start_count;
      start_base = s0;
      pulse_start();
      wait_idle(1'b0);
      check("restart_starts", start_count - s0, 2);
      if (start_count > s0) check("restart_first_write", {16'd0, log_q[s0]}, 32'h1280);
      check("restart_done", {30'd0, cfg_done, cfg_error}, 32'd2);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
